// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg -- shared fixed-point definitions for the neuron datapath.
//   TOTAL_BITS_DEF / FRACTION_BITS_DEF : default word format (Q4.12).
//   sat_max_f / sat_min_f               : two's-complement limits of a w-bit word.
//   SAT_MAX_DEF / SAT_MIN_DEF           : limits at the default width (0x7FFF / 0x8000).
//   acc_state_t                         : neuron accumulator state encoding.
package nn_fixed_pkg;

    localparam int TOTAL_BITS_DEF    = 16;
    localparam int FRACTION_BITS_DEF = 12;

    function automatic longint sat_max_f(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min_f(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint SAT_MAX_DEF = sat_max_f(TOTAL_BITS_DEF);
    localparam longint SAT_MIN_DEF = sat_min_f(TOTAL_BITS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/acc_saturate.sv
// acc_saturate -- combinational clamp of a wide accumulator to a TOTAL_BITS word.
// Ports:
//   i_acc  [ACC_W]      signed accumulator value
//   o_word [TOTAL_BITS] value clamped to [SAT_MIN, SAT_MAX]
//   o_sat               high when clamping changed the value
module acc_saturate
    import nn_fixed_pkg::*;
#(
    parameter int     TOTAL_BITS = TOTAL_BITS_DEF,
    parameter int     ACC_W      = TOTAL_BITS_DEF + 4,
    parameter longint SAT_MAX    = SAT_MAX_DEF,
    parameter longint SAT_MIN    = SAT_MIN_DEF
) (
    input  logic signed [ACC_W-1:0]      i_acc,
    output logic signed [TOTAL_BITS-1:0] o_word,
    output logic                         o_sat
);

    localparam logic signed [TOTAL_BITS-1:0] W_MAX = TOTAL_BITS'(SAT_MAX);
    localparam logic signed [TOTAL_BITS-1:0] W_MIN = TOTAL_BITS'(SAT_MIN);

    // The value fits in TOTAL_BITS exactly when every bit from the word's
    // sign bit upward is a copy of that sign bit.
    logic [ACC_W-TOTAL_BITS:0] w_hi;
    logic                      w_in_range;

    assign w_hi       = i_acc[ACC_W-1:TOTAL_BITS-1];
    assign w_in_range = (&w_hi) | ~(|w_hi);

    always_comb begin
        o_sat  = ~w_in_range;
        o_word = i_acc[TOTAL_BITS-1:0];
        if (!w_in_range) begin
            o_word = i_acc[ACC_W-1] ? W_MIN : W_MAX;
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator -- sums a bias plus LEN fixed-point products and emits
// one saturated result per neuron over a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, bias           begin a neuron (accepted in IDLE only), load bias
//   in_valid/in_ready     product handshake; in_data product, in_ovf its overflow flag
//   out_valid/out_ready   result handshake; out_data saturated sum, out_sat flag
//   busy                  high whenever not IDLE
// Build option: define NEURON_ACC_RELU_EN to clamp negative results to 0
// (out_sat still reflects saturation before the clamp).
module neuron_accumulator
    import nn_fixed_pkg::*;
#(
    parameter int TOTAL_BITS    = TOTAL_BITS_DEF,
    parameter int FRACTION_BITS = FRACTION_BITS_DEF,
    parameter int LEN           = 8,
    parameter int GUARD_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [TOTAL_BITS-1:0] bias,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TOTAL_BITS-1:0] in_data,
    input  logic                  in_ovf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TOTAL_BITS-1:0] out_data,
    output logic                  out_sat,
    output logic                  busy
);

    localparam int ACC_W = TOTAL_BITS + GUARD_BITS;
    localparam int CNT_W = 8;

    if (LEN < 1 || LEN > 255) begin : g_bad_len
        $error("neuron_accumulator: LEN must be in 1..255");
    end
    if (GUARD_BITS < $clog2(LEN + 1)) begin : g_bad_guard
        $error("neuron_accumulator: GUARD_BITS too small for LEN");
    end
    if (FRACTION_BITS > TOTAL_BITS - 1) begin : g_bad_frac
        $error("neuron_accumulator: FRACTION_BITS exceeds word width");
    end

    acc_state_t r_state;
    acc_state_t w_state_nxt;

    logic signed [ACC_W-1:0]      r_acc;
    logic        [CNT_W-1:0]      r_cnt;
    logic                         r_ovf;
    logic        [TOTAL_BITS-1:0] r_out_data;
    logic                         r_out_sat;

    logic                         w_load;
    logic                         w_xfer;
    logic                         w_last;
    logic signed [ACC_W-1:0]      w_acc_sum;
    logic signed [TOTAL_BITS-1:0] w_sat_word;
    logic                         w_sat_flag;
    logic        [TOTAL_BITS-1:0] w_out_word;

    // Decoded from the state register rather than in_ready so the handshake
    // does not loop back through the FSM output logic.
    assign w_load    = (r_state == ST_IDLE) & start;
    assign w_xfer    = (r_state == ST_ACC) & in_valid;
    assign w_last    = (r_cnt == CNT_W'(LEN - 1));
    assign w_acc_sum = r_acc + $signed({{GUARD_BITS{in_data[TOTAL_BITS-1]}}, in_data});

    // The result is clamped from the sum that includes the final product, so
    // out_data is ready the cycle the block enters OUT.
    acc_saturate #(
        .TOTAL_BITS (TOTAL_BITS),
        .ACC_W      (ACC_W),
        .SAT_MAX    (sat_max_f(TOTAL_BITS)),
        .SAT_MIN    (sat_min_f(TOTAL_BITS))
    ) u_sat (
        .i_acc  (w_acc_sum),
        .o_word (w_sat_word),
        .o_sat  (w_sat_flag)
    );

`ifdef NEURON_ACC_RELU_EN
    assign w_out_word = w_sat_word[TOTAL_BITS-1] ? '0 : w_sat_word;
`else
    assign w_out_word = w_sat_word;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                in_ready = 1'b1;
                if (w_xfer && w_last) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_load) begin
            r_acc <= $signed({{GUARD_BITS{bias[TOTAL_BITS-1]}}, bias});
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + 1'b1;
            r_ovf <= r_ovf | in_ovf;
            if (w_last) begin
                r_out_data <= w_out_word;
                r_out_sat  <= w_sat_flag | r_ovf | in_ovf;
            end
        end
    end

    assign out_data = r_out_data;
    assign out_sat  = r_out_sat;

endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter TOTAL_BITS, default 16: word width of products, bias and result.
REQ-002 SHALL have parameter FRACTION_BITS, default 12: fractional bits (Q4.12 at defaults).
REQ-003 SHALL have parameter LEN, default 8: products accumulated per neuron; legal range 1..255.
REQ-004 SHALL have parameter GUARD_BITS, default 4: accumulator headroom; GUARD_BITS >= clog2(LEN+1) is required.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins a neuron and loads bias.
REQ-008 SHALL have port bias  input  TOTAL_BITS  two's-complement bias, sampled with start.
REQ-009 SHALL have port in_valid  input  1  product word present on in_data.
REQ-010 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-011 SHALL have port in_data  input  TOTAL_BITS  two's-complement product from the multiplier stage.
REQ-012 SHALL have port in_ovf  input  1  multiplier overflow flag qualifying in_data.
REQ-013 SHALL have port out_valid  output  1  out_data holds a finished neuron sum.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-015 SHALL have port out_data  output  TOTAL_BITS  saturated result, same Q format as inputs.
REQ-016 SHALL have port out_sat  output  1  result saturated or any accepted product flagged overflow.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, ACC, OUT.
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 -> acc <= sign-extended bias, cnt <= 0, sticky_ovf <= 0, next ACC.
REQ-020 start SHALL be ignored in ACC and OUT.
REQ-021 ACC: in_ready=1; a transfer occurs only when in_valid & in_ready; each transfer adds sign-extended in_data to acc, increments cnt, ORs in_ovf into sticky_ovf.
REQ-022 Accumulator width SHALL be TOTAL_BITS+GUARD_BITS; no wrap can occur within bias plus LEN products.
REQ-023 On the transfer with cnt==LEN-1 the block SHALL go to OUT; out_valid SHALL rise the next cycle (latency 1 after last product).
REQ-024 out_data SHALL be acc saturated to [2^(TOTAL_BITS-1)-1, -2^(TOTAL_BITS-1)] (0x7FFF/0x8000 at defaults), registered on entry to OUT.
REQ-025 out_sat SHALL be (saturation occurred) OR sticky_ovf, registered with out_data.
REQ-026 OUT: in_ready=0; out_data/out_sat SHALL hold stable while out_valid & !out_ready; out_valid & out_ready -> IDLE next cycle.
REQ-027 Input 0x8000 SHALL be treated as plain -2^(TOTAL_BITS-1)/2^FRACTION_BITS (-8.0); no special case.
REQ-028 in_valid gaps in ACC SHALL stall accumulation without altering acc or cnt.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, acc=0, cnt=0, sticky_ovf=0, in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0.
REQ-030 Reset mid-neuron SHALL discard partial sum; next start begins fresh.

Configuration
REQ-031 With macro NEURON_ACC_RELU_EN defined, a negative saturated result SHALL be output as 0 (out_sat computed before ReLU); without it, out_data is the signed saturated result.

Structure
REQ-032 Shared package nn_fixed_pkg SHALL hold TOTAL_BITS/FRACTION_BITS defaults, saturation limit constants and the state typedef.
REQ-033 Saturation SHALL be a combinational sub-module acc_saturate (acc in, word and sat flag out).

Verification (LEN=4, defaults)
REQ-034 bias 0x0000, products 0x1000 x4 -> out_data 0x4000, out_sat 0.
REQ-035 bias 0x7000, products 0x1000 x4 (sum 11.0) -> out_data 0x7FFF, out_sat 1.
REQ-036 bias 0, products 0xF000 x4 -> out_data 0xC000; with NEURON_ACC_RELU_EN -> 0x0000, out_sat 0.
REQ-037 in_valid idle 2 cycles between products, out_ready low 3 cycles -> same sum, out_data stable, in_ready 0 in OUT, no extra transfer.
REQ-038 rst_n pulsed low after 2 products -> all outputs 0 immediately; new start with bias 0, products 0x0800 x4 -> 0x2000.
REQ-039 in_ovf=1 on one product, sum 0x1000 -> out_sat 1; start pulsed during ACC -> ignored, acc unchanged.
